wm_sequencer: RTL and testbench

- Control block for the weight-memory (WM) port of a convolution unit. It is the initiator that the unit's WM and weight FIFO respond to.
- Load phase: accepts kernel weights from the RISC-V side over a valid/ready handshake and writes them into WM at sequential addresses.
- Fetch phase: on request, reads one K×K kernel slice for a given (filter, depth) and shifts it into the weight FIFO. It then signals that the 25-tap window is ready for conv_enable.

---
 rtl/wm_sequencer_pkg.sv | 21 ++
 rtl/wm_addr_gen.sv | 47 ++++
 rtl/wm_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_wm_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wm_sequencer_pkg.sv
// Shared types and constants for the weight-memory sequencer and its address generator.
package wm_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_READY = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } wm_state_e;

  // Cycles between a WM read strobe and valid read data.
  localparam int WM_RD_LAT = 1;

  function automatic int slice_words(input int kernel_edge);
    return kernel_edge * kernel_edge;
  endfunction

  localparam int DEFAULT_KERNAL_SIZE = 5;
  localparam int DEFAULT_NUMBER_OF_WM = slice_words(DEFAULT_KERNAL_SIZE);

endpackage

// File: rtl/wm_addr_gen.sv
// WM address generator: base register plus running offset counter, shared by load and fetch.
// Address is combinational from the two registers; clear beats load beats increment.
module wm_addr_gen #(
  parameter int ADDRESS_BITS = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear_i,
  input  logic                    load_i,
  input  logic                    inc_i,
  input  logic [ADDRESS_BITS-1:0] base_i,
  output logic [ADDRESS_BITS-1:0] addr_o,
  output logic [ADDRESS_BITS-1:0] cnt_o
);

  logic [ADDRESS_BITS-1:0] base_q, base_d;
  logic [ADDRESS_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    base_d = base_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      // A clear paired with an increment means "restart and consume slot 0".
      base_d = '0;
      cnt_d  = inc_i ? ADDRESS_BITS'(1) : '0;
    end else if (load_i) begin
      base_d = base_i;
      cnt_d  = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + ADDRESS_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_q <= '0;
      cnt_q  <= '0;
    end else begin
      base_q <= base_d;
      cnt_q  <= cnt_d;
    end
  end

  assign addr_o = base_q + cnt_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/wm_sequencer.sv
// WM port initiator: loads weights over valid/ready, then streams one KxK slice into the weight FIFO.
// Fetch: reads on cycles 1..25, FIFO shifts 2..26, window_ready on 27; load stalls via load_ready.
module wm_sequencer
  import wm_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDRESS_BITS     = 15,
  parameter int KERNAL_SIZE      = 5,
  parameter int IFM_DEPTH        = 3,
  parameter int FILTERS_PER_UNIT = 3,
  parameter int NUMBER_OF_WM     = slice_words(KERNAL_SIZE),
  parameter int WM_DEPTH         = NUMBER_OF_WM * IFM_DEPTH * FILTERS_PER_UNIT,
  localparam int FW = (FILTERS_PER_UNIT > 1) ? $clog2(FILTERS_PER_UNIT) : 1,
  localparam int DW = (IFM_DEPTH > 1) ? $clog2(IFM_DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_valid,
  input  logic [DATA_WIDTH-1:0]   load_data,
  output logic                    load_ready,
  input  logic                    load_restart,
  output logic                    load_done,
  input  logic                    fetch_start,
  input  logic [FW-1:0]           fetch_filter,
  input  logic [DW-1:0]           fetch_depth,
  output logic                    fetch_busy,
  output logic                    window_ready,
  output logic                    fetch_err,
  output logic                    wm_enable_write,
  output logic                    wm_enable_read,
  output logic                    wm_fifo_enable,
  output logic [ADDRESS_BITS-1:0] wm_address,
  output logic [DATA_WIDTH-1:0]   wm_data
);

  localparam logic [FW-1:0] FILT_MAX = FW'(FILTERS_PER_UNIT - 1);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(IFM_DEPTH - 1);

  wm_state_e state_q, state_d;
  logic ready_q, ready_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic busy_q, busy_d;
  logic win_q, win_d;
  logic wr_q, wr_d;
  logic rd_q, rd_d;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [WM_RD_LAT-1:0] lat_q;

  logic ag_clear, ag_load, ag_inc;
  logic [ADDRESS_BITS-1:0] ag_addr, ag_cnt;
  logic [ADDRESS_BITS-1:0] fetch_base;
  logic fetch_legal, load_xfer, drain_done;

  assign fetch_legal = (fetch_filter <= FILT_MAX) && (fetch_depth <= DEPTH_MAX);
  assign fetch_base  = ADDRESS_BITS'((int'(fetch_filter) * IFM_DEPTH + int'(fetch_depth)) * NUMBER_OF_WM);
  assign load_xfer   = load_valid && ready_q;
  // Only the oldest stage may still be set when the final FIFO shift is on the output.
  assign drain_done  = ((lat_q << 1) == '0);

  wm_addr_gen #(
    .ADDRESS_BITS(ADDRESS_BITS)
  ) u_addr_gen (
    .clk    (clk),
    .reset  (reset),
    .clear_i(ag_clear),
    .load_i (ag_load),
    .inc_i  (ag_inc),
    .base_i (fetch_base),
    .addr_o (ag_addr),
    .cnt_o  (ag_cnt)
  );

  always_comb begin
    state_d  = state_q;
    ready_d  = 1'b0;
    done_d   = done_q;
    err_d    = err_q;
    busy_d   = busy_q;
    win_d    = 1'b0;
    wr_d     = 1'b0;
    rd_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    ag_clear = 1'b0;
    ag_load  = 1'b0;
    ag_inc   = 1'b0;
    case (state_q)
      ST_LOAD: begin
        ready_d = 1'b1;
        if (fetch_start) err_d = 1'b1;
        if (load_restart) ag_clear = 1'b1;
        if (load_xfer) begin
          wr_d   = 1'b1;
          addr_d = load_restart ? '0 : ag_addr;
          data_d = load_data;
          ag_inc = 1'b1;
          if (!load_restart && ag_cnt == ADDRESS_BITS'(WM_DEPTH - 1)) begin
            state_d  = ST_READY;
            ready_d  = 1'b0;
            done_d   = 1'b1;
            ag_clear = 1'b1;
            ag_inc   = 1'b0;
          end
        end
      end
      ST_READY: begin
        if (load_restart) begin
          state_d  = ST_LOAD;
          ready_d  = 1'b1;
          done_d   = 1'b0;
          ag_clear = 1'b1;
        end else if (fetch_start) begin
          if (fetch_legal) begin
            state_d = ST_READ;
            busy_d  = 1'b1;
            rd_d    = 1'b1;
            addr_d  = fetch_base;
            ag_load = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (ag_cnt == ADDRESS_BITS'(NUMBER_OF_WM - 1)) begin
          state_d = ST_DRAIN;
        end else begin
          rd_d   = 1'b1;
          addr_d = ag_addr + ADDRESS_BITS'(1);
          ag_inc = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_done) begin
          state_d = ST_READY;
          win_d   = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_LOAD;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      win_q   <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      win_q   <= win_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      lat_q   <= (lat_q << 1) | WM_RD_LAT'(rd_q);
    end
  end

  assign load_ready      = ready_q;
  assign load_done       = done_q;
  assign fetch_busy      = busy_q;
  assign window_ready    = win_q;
  assign fetch_err       = err_q;
  assign wm_enable_write = wr_q;
  assign wm_enable_read  = rd_q;
  assign wm_fifo_enable  = lat_q[WM_RD_LAT-1];
  assign wm_address      = addr_q;
  assign wm_data         = data_q;

endmodule

// File: tb/tb_wm_sequencer.sv
// Randomized bench for wm_sequencer with a timeline-level WM/FIFO reference model.
module tb_wm_sequencer;

  localparam int NWM   = 25;
  localparam int IDEP  = 3;
  localparam int DEPTH = 225;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_restart = 1'b0;
  logic        fetch_start = 1'b0;
  logic [1:0]  fetch_filter = '0;
  logic [1:0]  fetch_depth = '0;
  logic        load_ready, load_done, fetch_busy, window_ready, fetch_err;
  logic        wm_enable_write, wm_enable_read, wm_fifo_enable;
  logic [14:0] wm_address;
  logic [31:0] wm_data;

  wm_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .load_valid     (load_valid),
    .load_data      (load_data),
    .load_ready     (load_ready),
    .load_restart   (load_restart),
    .load_done      (load_done),
    .fetch_start    (fetch_start),
    .fetch_filter   (fetch_filter),
    .fetch_depth    (fetch_depth),
    .fetch_busy     (fetch_busy),
    .window_ready   (window_ready),
    .fetch_err      (fetch_err),
    .wm_enable_write(wm_enable_write),
    .wm_enable_read (wm_enable_read),
    .wm_fifo_enable (wm_fifo_enable),
    .wm_address     (wm_address),
    .wm_data        (wm_data)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference WM contents and observed-event logs.
  logic [31:0] wm_mem [0:DEPTH-1];
  int          wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  logic        wr_done_log[$];
  int          rd_cyc_log[$];
  int          rd_addr_log[$];
  int          fifo_cyc_log[$];
  int          win_cyc_log[$];
  logic [31:0] taps[$];
  int          overlap = 0;
  logic        prev_rd = 1'b0;
  int          prev_addr = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (wm_enable_write && wm_enable_read) overlap++;
    if (wm_enable_write) begin
      wr_addr_log.push_back(int'(wm_address));
      wr_data_log.push_back(wm_data);
      wr_done_log.push_back(load_done);
      if (int'(wm_address) < DEPTH) wm_mem[wm_address] = wm_data;
    end
    if (wm_fifo_enable) begin
      fifo_cyc_log.push_back(cyc);
      taps.push_back((prev_rd && prev_addr < DEPTH) ? wm_mem[prev_addr] : 32'hDEADBEEF);
      if (taps.size() > NWM) void'(taps.pop_front());
    end
    if (wm_enable_read) begin
      rd_cyc_log.push_back(cyc);
      rd_addr_log.push_back(int'(wm_address));
    end
    if (window_ready) win_cyc_log.push_back(cyc);
    prev_rd   = wm_enable_read;
    prev_addr = int'(wm_address);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_addr_log.delete();
    wr_data_log.delete();
    wr_done_log.delete();
    rd_cyc_log.delete();
    rd_addr_log.delete();
    fifo_cyc_log.delete();
    win_cyc_log.delete();
    taps.delete();
  endtask

  task automatic do_load();
    int idx = 0;
    int guard = 0;
    int bad = 0;
    int early = 0;
    logic xfer;
    clear_logs();
    while (idx < DEPTH && guard < 4000) begin
      load_valid = ($urandom_range(3) != 0);
      load_data  = idx;
      xfer = load_valid && load_ready;
      step();
      if (xfer) idx++;
      guard++;
    end
    load_valid = 1'b0;
    step();
    check("load_finished", idx, DEPTH);
    check("wr_count", wr_addr_log.size(), DEPTH);
    for (int i = 0; i < wr_addr_log.size(); i++) begin
      if (wr_addr_log[i] != i || wr_data_log[i] != i) bad++;
      if (i < wr_addr_log.size() - 1 && wr_done_log[i]) early++;
    end
    check("wr_addr_data", bad, 0);
    check("done_before_last", early, 0);
    check("done_with_last", (wr_done_log.size() > 0) ? wr_done_log[wr_done_log.size()-1] : 1'b0, 1);
    check("load_done_level", load_done, 1);
    check("load_ready_after", load_ready, 0);
  endtask

  task automatic do_fetch(input int f, input int d, input int repulse);
    int base = (f * IDEP + d) * NWM;
    int c0;
    int bad_rd = 0;
    int bad_fifo = 0;
    int bad_tap = 0;
    clear_logs();
    fetch_filter = f[1:0];
    fetch_depth  = d[1:0];
    fetch_start  = 1'b1;
    c0 = cyc;
    step();
    fetch_start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k == repulse) begin
        fetch_filter = 2'($urandom_range(3));
        fetch_depth  = 2'($urandom_range(3));
        fetch_start  = 1'b1;
      end
      step();
      fetch_start = 1'b0;
    end
    check("rd_count", rd_cyc_log.size(), NWM);
    for (int i = 0; i < rd_cyc_log.size(); i++)
      if (rd_cyc_log[i] != c0 + 1 + i || rd_addr_log[i] != base + i) bad_rd++;
    check("rd_timing_addr", bad_rd, 0);
    check("fifo_count", fifo_cyc_log.size(), NWM);
    for (int i = 0; i < fifo_cyc_log.size(); i++)
      if (fifo_cyc_log[i] != c0 + 2 + i) bad_fifo++;
    check("fifo_timing", bad_fifo, 0);
    check("win_count", win_cyc_log.size(), 1);
    check("win_cycle", (win_cyc_log.size() > 0) ? win_cyc_log[0] - c0 : -1, 27);
    check("tap_count", taps.size(), NWM);
    for (int i = 0; i < taps.size(); i++)
      if (taps[i] != base + i) bad_tap++;
    check("tap_data", bad_tap, 0);
    check("busy_after_fetch", fetch_busy, 0);
    check("err_after_legal", fetch_err, 0);
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) step();
    check("rst_flags", {load_ready, load_done, fetch_busy, window_ready, fetch_err,
                        wm_enable_write, wm_enable_read, wm_fifo_enable}, 0);
    check("rst_addr", wm_address, 0);
    check("rst_data", wm_data, 0);
    reset = 1'b1;
    #1;
    check("ready_at_release", load_ready, 0);
    step();
    check("ready_after_release", load_ready, 1);

    do_load();

    do_fetch(1, 2, 10);
    do_fetch($urandom_range(2), $urandom_range(2), 10);
    do_fetch($urandom_range(2), $urandom_range(2), $urandom_range(26, 3));

    // Illegal indices in READY.
    clear_logs();
    fetch_filter = 2'd3;
    fetch_depth  = 2'($urandom_range(2));
    fetch_start  = 1'b1;
    step();
    fetch_start = 1'b0;
    repeat (30) step();
    check("illegal_filter_reads", rd_cyc_log.size(), 0);
    check("illegal_filter_err", fetch_err, 1);
    check("illegal_filter_busy", fetch_busy, 0);
    fetch_filter = 2'($urandom_range(2));
    fetch_depth  = 2'd3;
    fetch_start  = 1'b1;
    step();
    fetch_start = 1'b0;
    repeat (30) step();
    check("illegal_depth_reads", rd_cyc_log.size(), 0);
    // Still in READY: a legal fetch works (error flag stays set).
    clear_logs();
    fetch_filter = 2'd0;
    fetch_depth  = 2'd0;
    fetch_start  = 1'b1;
    step();
    fetch_start = 1'b0;
    repeat (30) step();
    check("post_illegal_reads", rd_cyc_log.size(), NWM);
    check("post_illegal_win", win_cyc_log.size(), 1);

    // Restart and fetch together: restart wins.
    clear_logs();
    load_restart = 1'b1;
    fetch_start  = 1'b1;
    fetch_filter = 2'd0;
    fetch_depth  = 2'd1;
    step();
    load_restart = 1'b0;
    fetch_start  = 1'b0;
    check("restart_done", load_done, 0);
    check("restart_ready", load_ready, 1);
    repeat (3) step();
    check("restart_no_reads", rd_cyc_log.size(), 0);
    do_load();

    // Reset in the middle of a READ.
    clear_logs();
    fetch_filter = 2'd2;
    fetch_depth  = 2'd2;
    fetch_start  = 1'b1;
    step();
    fetch_start = 1'b0;
    repeat (11) step();
    #2;
    reset = 1'b0;
    #1;
    check("midrst_strobes", {wm_enable_read, wm_enable_write, wm_fifo_enable,
                             fetch_busy, load_done, window_ready}, 0);
    repeat (2) step();
    reset = 1'b1;
    check("midrst_err_cleared", fetch_err, 0);
    step();
    check("midrst_ready", load_ready, 1);
    check("midrst_done", load_done, 0);

    // fetch_start while loading is flagged and ignored.
    clear_logs();
    fetch_filter = 2'd0;
    fetch_depth  = 2'd0;
    fetch_start  = 1'b1;
    step();
    fetch_start = 1'b0;
    repeat (5) step();
    check("load_fetch_err", fetch_err, 1);
    check("load_fetch_reads", rd_cyc_log.size(), 0);

    check("rd_wr_overlap", overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
